alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 75 +++++++
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bus bundle for alu_arbiter: two requester channels, two response channels,
// the ALU-side enables/operands/results and the IRQ clear/pending signals.
interface alu_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  logic              req_a_valid;
  logic              req_a_ready;
  logic [1:0]        req_a_op;
  logic [DATA_W-1:0] req_a_in_a;
  logic [DATA_W-1:0] req_a_in_b;

  logic              req_b_valid;
  logic              req_b_ready;
  logic [1:0]        req_b_op;
  logic [DATA_W-1:0] req_b_in_a;
  logic [DATA_W-1:0] req_b_in_b;

  logic              rsp_a_valid;
  logic              rsp_a_ready;
  logic [DATA_W-1:0] rsp_a_data;
  logic              rsp_a_irq;

  logic              rsp_b_valid;
  logic              rsp_b_ready;
  logic [DATA_W-1:0] rsp_b_data;
  logic              rsp_b_irq;

  logic              alu_enable;
  logic              alu_enable_a;
  logic              alu_enable_b;
  logic [1:0]        alu_op_a;
  logic [1:0]        alu_op_b;
  logic [DATA_W-1:0] alu_in_a;
  logic [DATA_W-1:0] alu_in_b;
  logic [DATA_W-1:0] alu_out;
  logic              alu_irq;
  logic              alu_irq_clr;

  logic              irq_clr;
  logic              irq_pending;

  // Arbiter side
  modport slave (
    input  req_a_valid, req_a_op, req_a_in_a, req_a_in_b,
    output req_a_ready,
    input  req_b_valid, req_b_op, req_b_in_a, req_b_in_b,
    output req_b_ready,
    output rsp_a_valid, rsp_a_data, rsp_a_irq,
    input  rsp_a_ready,
    output rsp_b_valid, rsp_b_data, rsp_b_irq,
    input  rsp_b_ready,
    output alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
    output alu_in_a, alu_in_b, alu_irq_clr,
    input  alu_out, alu_irq,
    input  irq_clr,
    output irq_pending
  );

  // Requester / ALU / software side
  modport master (
    output req_a_valid, req_a_op, req_a_in_a, req_a_in_b,
    input  req_a_ready,
    output req_b_valid, req_b_op, req_b_in_a, req_b_in_b,
    input  req_b_ready,
    input  rsp_a_valid, rsp_a_data, rsp_a_irq,
    output rsp_a_ready,
    input  rsp_b_valid, rsp_b_data, rsp_b_irq,
    output rsp_b_ready,
    input  alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
    input  alu_in_a, alu_in_b, alu_irq_clr,
    output alu_out, alu_irq,
    output irq_clr,
    input  irq_pending
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters (A: mode-a ops,
// B: mode-b ops). One transaction in flight: grant, issue one cycle, wait
// ALU_LAT cycles, hold the response until the owner accepts it.
module alu_arbiter #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ALU_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  localparam logic [2:0] LP_LAT = ALU_LAT[2:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_last_b;   // 1: B was granted last, so A wins the next tie
  logic              r_gnt_b;    // owner of the transaction in flight
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_in_a;
  logic [DATA_W-1:0] r_in_b;
  logic [2:0]        r_cnt;
  logic [DATA_W-1:0] r_rsp_a_data;
  logic [DATA_W-1:0] r_rsp_b_data;
  logic              r_rsp_a_irq;
  logic              r_rsp_b_irq;
  logic              r_irq_clr_d;
  logic              r_irq_pending;

  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_accept;

  assign w_grant_a = bus.req_a_valid & (~bus.req_b_valid | r_last_b);
  assign w_grant_b = bus.req_b_valid & (~bus.req_a_valid | ~r_last_b);
  assign w_accept  = (r_state == S_IDLE) & (w_grant_a | w_grant_b);

  assign bus.rsp_a_data  = r_rsp_a_data;
  assign bus.rsp_b_data  = r_rsp_b_data;
  assign bus.rsp_a_irq   = r_rsp_a_irq;
  assign bus.rsp_b_irq   = r_rsp_b_irq;
  assign bus.alu_irq_clr = r_irq_clr_d;
  assign bus.irq_pending = r_irq_pending;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and state-dependent outputs
  always_comb begin
    w_state_nxt      = r_state;
    bus.req_a_ready  = 1'b0;
    bus.req_b_ready  = 1'b0;
    bus.rsp_a_valid  = 1'b0;
    bus.rsp_b_valid  = 1'b0;
    bus.alu_enable   = 1'b0;
    bus.alu_enable_a = 1'b0;
    bus.alu_enable_b = 1'b0;
    bus.alu_op_a     = '0;
    bus.alu_op_b     = '0;
    bus.alu_in_a     = '0;
    bus.alu_in_b     = '0;
    case (r_state)
      S_IDLE: begin
        bus.req_a_ready = w_grant_a;
        bus.req_b_ready = w_grant_b;
        if (w_grant_a | w_grant_b) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        bus.alu_enable   = 1'b1;
        bus.alu_enable_a = ~r_gnt_b;
        bus.alu_enable_b = r_gnt_b;
        bus.alu_op_a     = r_gnt_b ? 2'b00 : r_op;
        bus.alu_op_b     = r_gnt_b ? r_op : 2'b00;
        bus.alu_in_a     = r_in_a;
        bus.alu_in_b     = r_in_b;
        w_state_nxt      = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == LP_LAT) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.rsp_a_valid = ~r_gnt_b;
        bus.rsp_b_valid = r_gnt_b;
        if (r_gnt_b ? bus.rsp_b_ready : bus.rsp_a_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant bookkeeping, request latch, latency counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_b     <= 1'b1;
      r_gnt_b      <= 1'b0;
      r_op         <= '0;
      r_in_a       <= '0;
      r_in_b       <= '0;
      r_cnt        <= '0;
      r_rsp_a_data <= '0;
      r_rsp_b_data <= '0;
      r_rsp_a_irq  <= 1'b0;
      r_rsp_b_irq  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_gnt_b  <= w_grant_b;
        r_last_b <= w_grant_b;
        r_op     <= w_grant_b ? bus.req_b_op   : bus.req_a_op;
        r_in_a   <= w_grant_b ? bus.req_b_in_a : bus.req_a_in_a;
        r_in_b   <= w_grant_b ? bus.req_b_in_b : bus.req_a_in_b;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= 3'd1;
      end else if (r_state == S_WAIT) begin
        if (r_cnt == LP_LAT) begin
          r_cnt <= '0;
          if (r_gnt_b) begin
            r_rsp_b_data <= bus.alu_out;
            r_rsp_b_irq  <= bus.alu_irq;
          end else begin
            r_rsp_a_data <= bus.alu_out;
            r_rsp_a_irq  <= bus.alu_irq;
          end
        end else begin
          r_cnt <= r_cnt + 3'd1;
        end
      end
    end
  end

  // IRQ clear forwarding and pending mirror, independent of the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_clr_d   <= 1'b0;
      r_irq_pending <= 1'b0;
    end else begin
      r_irq_clr_d   <= bus.irq_clr;
      r_irq_pending <= bus.alu_irq;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: default-latency DUT plus an ALU_LAT=3 DUT,
// each with a small behavioural ALU (00 AND, 01 XOR, 10 ADD, 11 OR).
module tb_alu_arbiter;

  logic clk;
  logic rst;
  logic irq_on_next;
  int   n_checks;
  int   n_errors;

  alu_arbiter_if #(.DATA_W(8)) b1 ();
  alu_arbiter_if #(.DATA_W(8)) b3 ();

  alu_arbiter #(.DATA_W(8), .ALU_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  alu_arbiter #(.DATA_W(8), .ALU_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a ^ b;
      2'b10:   return a + b;
      default: return a | b;
    endcase
  endfunction

  // ALU model for the single-cycle DUT
  always @(posedge clk) begin
    if (rst) begin
      b1.alu_out <= '0;
      b1.alu_irq <= 1'b0;
    end else if (b1.alu_enable) begin
      b1.alu_out <= alu_f(b1.alu_enable_b ? b1.alu_op_b : b1.alu_op_a, b1.alu_in_a, b1.alu_in_b);
      b1.alu_irq <= irq_on_next;
    end else if (b1.alu_irq_clr) begin
      b1.alu_irq <= 1'b0;
    end
  end

  // ALU model for the three-cycle DUT
  logic [7:0] s1, s2;
  always @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      b3.alu_out <= '0;
      b3.alu_irq <= 1'b0;
    end else begin
      s1 <= b3.alu_enable ? alu_f(b3.alu_enable_b ? b3.alu_op_b : b3.alu_op_a, b3.alu_in_a, b3.alu_in_b) : s1;
      s2 <= s1;
      b3.alu_out <= s2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    irq_on_next = 1'b0;
    rst = 1'b1;
    b1.req_a_valid = 0; b1.req_a_op = 0; b1.req_a_in_a = 0; b1.req_a_in_b = 0;
    b1.req_b_valid = 0; b1.req_b_op = 0; b1.req_b_in_a = 0; b1.req_b_in_b = 0;
    b1.rsp_a_ready = 0; b1.rsp_b_ready = 0; b1.irq_clr = 0;
    b3.req_a_valid = 0; b3.req_a_op = 0; b3.req_a_in_a = 0; b3.req_a_in_b = 0;
    b3.req_b_valid = 0; b3.req_b_op = 0; b3.req_b_in_a = 0; b3.req_b_in_b = 0;
    b3.rsp_a_ready = 0; b3.rsp_b_ready = 0; b3.irq_clr = 0;

    // Reset state
    tick(); tick();
    chk("rst_a_ready", b1.req_a_ready, 0);
    chk("rst_rsp_a_valid", b1.rsp_a_valid, 0);
    chk("rst_rsp_b_valid", b1.rsp_b_valid, 0);
    chk("rst_alu_enable", b1.alu_enable, 0);
    chk("rst_irq_pending", b1.irq_pending, 0);
    chk("rst_alu_irq_clr", b1.alu_irq_clr, 0);
    chk("rst_rsp_a_data", b1.rsp_a_data, 0);
    rst = 1'b0;
    tick();

    // A only, AND F0 & 3C
    b1.req_a_valid = 1; b1.req_a_op = 2'b00; b1.req_a_in_a = 8'hF0; b1.req_a_in_b = 8'h3C;
    #1;
    chk("a_only_a_ready", b1.req_a_ready, 1);
    chk("a_only_b_ready", b1.req_b_ready, 0);
    tick(); b1.req_a_valid = 0; #1;
    chk("a_only_en", b1.alu_enable, 1);
    chk("a_only_en_a", b1.alu_enable_a, 1);
    chk("a_only_en_b", b1.alu_enable_b, 0);
    chk("a_only_op_a", b1.alu_op_a, 0);
    chk("a_only_in_a", b1.alu_in_a, 8'hF0);
    chk("a_only_in_b", b1.alu_in_b, 8'h3C);
    chk("a_only_ready_pulse", b1.req_a_ready, 0);
    tick();
    chk("a_only_t2_valid", b1.rsp_a_valid, 0);
    chk("a_only_t2_en", b1.alu_enable, 0);
    chk("a_only_t2_in_a", b1.alu_in_a, 0);
    tick();
    chk("a_only_t3_valid", b1.rsp_a_valid, 1);
    chk("a_only_t3_data", b1.rsp_a_data, 8'h30);
    chk("a_only_t3_b_valid", b1.rsp_b_valid, 0);
    chk("a_only_t3_irq", b1.rsp_a_irq, 0);
    b1.rsp_a_ready = 1; tick(); b1.rsp_a_ready = 0; #1;
    chk("a_only_done", b1.rsp_a_valid, 0);

    // Tie after reset: A first, then B, then A again
    rst = 1; tick(); rst = 0;
    b1.req_a_valid = 1; b1.req_a_op = 2'b10; b1.req_a_in_a = 8'h12; b1.req_a_in_b = 8'h34;
    b1.req_b_valid = 1; b1.req_b_op = 2'b11; b1.req_b_in_a = 8'h0F; b1.req_b_in_b = 8'hF0;
    #1;
    chk("tie1_a_ready", b1.req_a_ready, 1);
    chk("tie1_b_ready", b1.req_b_ready, 0);
    tick(); b1.req_a_valid = 0; #1;
    chk("tie1_en_a", b1.alu_enable_a, 1);
    chk("tie1_op_a", b1.alu_op_a, 2);
    chk("tie1_b_ready_issue", b1.req_b_ready, 0);
    tick();
    chk("tie1_b_ready_wait", b1.req_b_ready, 0);
    tick();
    chk("tie1_rsp_a_valid", b1.rsp_a_valid, 1);
    chk("tie1_rsp_a_data", b1.rsp_a_data, 8'h46);
    chk("tie1_b_ready_resp", b1.req_b_ready, 0);
    b1.rsp_a_ready = 1; tick(); b1.rsp_a_ready = 0; #1;
    chk("tie2_b_ready", b1.req_b_ready, 1);
    chk("tie2_a_ready", b1.req_a_ready, 0);
    tick(); b1.req_b_valid = 0; #1;
    chk("tie2_en_b", b1.alu_enable_b, 1);
    chk("tie2_en_a", b1.alu_enable_a, 0);
    chk("tie2_op_b", b1.alu_op_b, 3);
    chk("tie2_op_a", b1.alu_op_a, 0);
    chk("tie2_in_a", b1.alu_in_a, 8'h0F);
    chk("tie2_in_b", b1.alu_in_b, 8'hF0);
    tick(); tick();
    chk("tie2_rsp_b_valid", b1.rsp_b_valid, 1);
    chk("tie2_rsp_b_data", b1.rsp_b_data, 8'hFF);
    chk("tie2_rsp_a_valid", b1.rsp_a_valid, 0);
    b1.rsp_b_ready = 1; tick(); b1.rsp_b_ready = 0;

    // Third tie goes to A; A response back-pressured for 10 cycles
    b1.req_a_valid = 1; b1.req_a_op = 2'b01; b1.req_a_in_a = 8'hF0; b1.req_a_in_b = 8'h3C;
    b1.req_b_valid = 1; b1.req_b_op = 2'b00; b1.req_b_in_a = 8'hAF; b1.req_b_in_b = 8'hF5;
    #1;
    chk("tie3_a_ready", b1.req_a_ready, 1);
    chk("tie3_b_ready", b1.req_b_ready, 0);
    tick(); b1.req_a_valid = 0;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_a_valid", b1.rsp_a_valid, 1);
      chk("bp_rsp_a_data", b1.rsp_a_data, 8'hCC);
      chk("bp_b_ready", b1.req_b_ready, 0);
      tick();
    end
    b1.rsp_a_ready = 1; #1;
    chk("bp_hs_valid", b1.rsp_a_valid, 1);
    irq_on_next = 1;
    tick(); b1.rsp_a_ready = 0; #1;
    chk("bp_then_b_ready", b1.req_b_ready, 1);
    tick(); b1.req_b_valid = 0;
    tick(); tick();
    irq_on_next = 0;
    chk("irq_rsp_b_valid", b1.rsp_b_valid, 1);
    chk("irq_rsp_b_data", b1.rsp_b_data, 8'hA5);
    chk("irq_rsp_b_irq", b1.rsp_b_irq, 1);
    chk("irq_pending_set", b1.irq_pending, 1);

    // irq_clr pulse forwarded one cycle later, one cycle wide
    b1.irq_clr = 1; #1;
    chk("irq_clr_c0", b1.alu_irq_clr, 0);
    tick(); b1.irq_clr = 0; #1;
    chk("irq_clr_c1", b1.alu_irq_clr, 1);
    tick();
    chk("irq_clr_c2", b1.alu_irq_clr, 0);
    tick();
    chk("irq_pending_clr", b1.irq_pending, 0);
    chk("irq_rsp_b_irq_stable", b1.rsp_b_irq, 1);
    b1.rsp_b_ready = 1; tick(); b1.rsp_b_ready = 0; #1;
    chk("irq_rsp_b_done", b1.rsp_b_valid, 0);

    // B valid pulsing while busy leaves no grant behind
    b1.req_a_valid = 1; b1.req_a_op = 2'b00; b1.req_a_in_a = 8'hFF; b1.req_a_in_b = 8'h0F;
    #1;
    chk("drop_a_ready", b1.req_a_ready, 1);
    tick(); b1.req_a_valid = 0; b1.req_b_valid = 1; #1;
    chk("drop_b_ready_busy", b1.req_b_ready, 0);
    tick(); b1.req_b_valid = 0;
    tick();
    chk("drop_rsp_a_data", b1.rsp_a_data, 8'h0F);
    b1.rsp_a_ready = 1; tick(); b1.rsp_a_ready = 0; #1;
    chk("drop_idle_b_ready", b1.req_b_ready, 0);
    tick();
    chk("drop_no_issue", b1.alu_enable, 0);

    // Reset during WAIT aborts the transaction
    b1.req_a_valid = 1; b1.req_a_op = 2'b01; b1.req_a_in_a = 8'h0F; b1.req_a_in_b = 8'hFF;
    #1;
    tick(); b1.req_a_valid = 0;
    tick();
    rst = 1; tick(); rst = 0;
    chk("abort_rsp_a_valid", b1.rsp_a_valid, 0);
    chk("abort_alu_enable", b1.alu_enable, 0);
    chk("abort_rsp_a_data", b1.rsp_a_data, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_rsp", b1.rsp_a_valid, 0);
    end

    // ALU_LAT=3: response first valid at T+5
    b3.req_a_valid = 1; b3.req_a_op = 2'b10; b3.req_a_in_a = 8'h01; b3.req_a_in_b = 8'h02;
    #1;
    chk("lat3_a_ready", b3.req_a_ready, 1);
    tick(); b3.req_a_valid = 0; #1;
    chk("lat3_en_a", b3.alu_enable_a, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lat3_not_yet", b3.rsp_a_valid, 0);
    end
    tick();
    chk("lat3_rsp_valid", b3.rsp_a_valid, 1);
    chk("lat3_rsp_data", b3.rsp_a_data, 8'h03);
    b3.rsp_a_ready = 1; tick(); b3.rsp_a_ready = 0; #1;
    chk("lat3_done", b3.rsp_a_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
